threeadder_stream_unloader: RTL

THREEADDER_STREAM_UNLOADER -- requirements
Module: threeadder_stream_unloader

---
 rtl/threeadder_stream_unloader.sv | 91 +++++++++
 1 files changed

// File: rtl/threeadder_stream_unloader.sv
// threeadder_stream_unloader: loads a, b, c, registers the pairwise and triple sums, and streams them out as x, y, z, f.
module threeadder_stream_unloader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);
  typedef enum logic [2:0] {
    LOAD_A, LOAD_B, LOAD_C, COMPUTE, SEND_X, SEND_Y, SEND_Z, SEND_F
  } state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, c_q, x_q, y_q, z_q, f_q;
  logic [3:0] ovf_q;
  logic [WIDTH:0] sum_x, sum_y, sum_z;
  logic [WIDTH+1:0] sum_f;
  logic in_fire, out_fire;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign sum_x = {1'b0, a_q} + {1'b0, b_q};
  assign sum_y = {1'b0, b_q} + {1'b0, c_q};
  assign sum_z = {1'b0, a_q} + {1'b0, c_q};
  assign sum_f = {2'b0, a_q} + {2'b0, b_q} + {2'b0, c_q};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD_A;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:  state_d = in_fire ? LOAD_B : LOAD_A;
      LOAD_B:  state_d = in_fire ? LOAD_C : LOAD_B;
      LOAD_C:  state_d = in_fire ? COMPUTE : LOAD_C;
      COMPUTE: state_d = SEND_X;
      SEND_X:  state_d = out_fire ? SEND_Y : SEND_X;
      SEND_Y:  state_d = out_fire ? SEND_Z : SEND_Y;
      SEND_Z:  state_d = out_fire ? SEND_F : SEND_Z;
      SEND_F:  state_d = out_fire ? LOAD_A : SEND_F;
      default: state_d = LOAD_A;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else if (in_fire) begin
      if (state_q == LOAD_A) a_q <= in_data;
      if (state_q == LOAD_B) b_q <= in_data;
      if (state_q == LOAD_C) c_q <= in_data;
    end
  end
  // results are captured once per frame and held for the whole send phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      f_q   <= '0;
      ovf_q <= '0;
    end else if (state_q == COMPUTE) begin
      x_q   <= sum_x[WIDTH-1:0];
      y_q   <= sum_y[WIDTH-1:0];
      z_q   <= sum_z[WIDTH-1:0];
      f_q   <= sum_f[WIDTH-1:0];
      ovf_q <= {|sum_f[WIDTH+1:WIDTH], sum_z[WIDTH], sum_y[WIDTH], sum_x[WIDTH]};
    end
  end
  always_comb begin
    in_ready  = state_q inside {LOAD_A, LOAD_B, LOAD_C};
    out_valid = state_q inside {SEND_X, SEND_Y, SEND_Z, SEND_F};
    out_last  = state_q == SEND_F;
    busy      = state_q != LOAD_A;
    out_data  = state_q == SEND_X ? x_q :
                state_q == SEND_Y ? y_q :
                state_q == SEND_Z ? z_q :
                state_q == SEND_F ? f_q : '0;
    out_ovf   = state_q == SEND_X ? ovf_q[0] :
                state_q == SEND_Y ? ovf_q[1] :
                state_q == SEND_Z ? ovf_q[2] :
                state_q == SEND_F ? ovf_q[3] : 1'b0;
  end
endmodule
